// File: rtl/chaos_sbox_gen.sv
// Chaotic S-box generator: iterates a fixed-point logistic map and keeps first-seen quantised values,
// building a bijective forward table and its inverse, with an ascending fallback fill after MAX_ITER steps.
module chaos_sbox_gen #(
   parameter int SBOX_BITS = 8,
   parameter int FRAC_W    = 16,
   parameter int R_Q       = 261489,
   parameter int MAX_ITER  = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [FRAC_W-1:0]    seed,
   output logic                 busy,
   output logic                 done,
   input  logic [SBOX_BITS-1:0] rd_addr,
   input  logic                 rd_inv,
   output logic [SBOX_BITS-1:0] rd_data
);
   localparam int N  = 1 << SBOX_BITS;
   localparam int CW = SBOX_BITS + 1;
   localparam int IW = $clog2(MAX_ITER + 1);
   localparam logic [CW-1:0]     N_CNT    = CW'(N);
   localparam logic [IW-1:0]     ITER_LIM = IW'(MAX_ITER);
   localparam logic [FRAC_W+1:0] R_K      = (FRAC_W+2)'(R_Q);

   typedef enum logic [1:0] {IDLE, ITER, FILL, DONE} state_t;

   state_t               state;
   logic [FRAC_W-1:0]    x;
   logic [CW-1:0]        count;
   logic [IW-1:0]        iter;
   logic [SBOX_BITS-1:0] scan;
   logic [N-1:0]         used;
   logic [SBOX_BITS-1:0] fwd [N];
   logic [SBOX_BITS-1:0] inv [N];

   logic [FRAC_W:0]      one_minus_x;
   logic [2*FRAC_W:0]    prod1;
   logic [FRAC_W:0]      p1;
   logic [2*FRAC_W+2:0]  prod2;
   logic [FRAC_W+2:0]    x_raw;
   logic [FRAC_W-1:0]    x_next;
   logic [SBOX_BITS-1:0] cand;
   logic                 wr_en;
   logic [SBOX_BITS-1:0] wr_val;
   logic [CW-1:0]        count_inc;

   // Full-width products, truncation by shift only
   assign one_minus_x = {1'b1, {FRAC_W{1'b0}}} - {1'b0, x};
   assign prod1       = {{(FRAC_W+1){1'b0}}, x} * {{FRAC_W{1'b0}}, one_minus_x};
   assign p1          = (FRAC_W+1)'(prod1 >> FRAC_W);
   assign prod2       = {{(FRAC_W+1){1'b0}}, R_K} * {{(FRAC_W+2){1'b0}}, p1};
   assign x_raw       = (FRAC_W+3)'(prod2 >> FRAC_W);
   assign x_next      = (|x_raw[FRAC_W+2:FRAC_W]) ? {FRAC_W{1'b1}} : x_raw[FRAC_W-1:0];
   assign cand        = x_next[FRAC_W-1 -: SBOX_BITS];

   always_comb begin
      wr_en  = 1'b0;
      wr_val = cand;
      if (state == ITER) begin
         wr_en = !used[cand];
      end else if (state == FILL) begin
         wr_en  = !used[scan];
         wr_val = scan;
      end
   end

   assign count_inc = count + CW'(wr_en);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         rd_data <= '0;
         x       <= '0;
         count   <= '0;
         iter    <= '0;
         scan    <= '0;
         used    <= '0;
      end else begin
         rd_data <= rd_inv ? inv[rd_addr] : fwd[rd_addr];
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  // Zero is a fixed point of the map, so it is nudged to the smallest nonzero state
                  x     <= (seed == '0) ? FRAC_W'(1) : seed;
                  used  <= '0;
                  count <= '0;
                  iter  <= '0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  state <= ITER;
               end
            end
            ITER: begin
               if (wr_en) used[wr_val] <= 1'b1;
               count <= count_inc;
               x     <= x_next;
               iter  <= iter + IW'(1);
               if (count_inc == N_CNT) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (iter + IW'(1) == ITER_LIM) begin
                  state <= FILL;
                  scan  <= '0;
               end
            end
            FILL: begin
               if (wr_en) used[wr_val] <= 1'b1;
               count <= count_inc;
               scan  <= scan + SBOX_BITS'(1);
               if (count_inc == N_CNT) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Table storage carries no reset so it can map onto block RAM
   always_ff @(posedge clk) begin
      if (wr_en) begin
         fwd[count[SBOX_BITS-1:0]] <= wr_val;
         inv[wr_val]               <= count[SBOX_BITS-1:0];
      end
   end

endmodule

// File: tb/tb_chaos_sbox_gen.sv
// Bench for chaos_sbox_gen: three parameterisations checked against a behavioural logistic-map model.
module tb_chaos_sbox_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_d, start_f, start_s;
   logic [15:0] seed_d, seed_f;
   logic [11:0] seed_s;
   logic        busy_d, busy_f, busy_s, done_d, done_f, done_s;
   logic [7:0]  addr_d, addr_f, data_d, data_f;
   logic [3:0]  addr_s, data_s;
   logic        inv_d, inv_f, inv_s;

   int vectors = 0, miscompares = 0;
   int exp_fwd[256], exp_inv[256];
   int exp_lat, exp_pref;
   logic pend_en[3], cmp_en[3];
   int   pend_exp[3], cmp_exp[3];

   chaos_sbox_gen u_def (.clk(clk), .rst(rst), .start(start_d), .seed(seed_d), .busy(busy_d),
      .done(done_d), .rd_addr(addr_d), .rd_inv(inv_d), .rd_data(data_d));
   chaos_sbox_gen #(.MAX_ITER(16)) u_fb (.clk(clk), .rst(rst), .start(start_f), .seed(seed_f),
      .busy(busy_f), .done(done_f), .rd_addr(addr_f), .rd_inv(inv_f), .rd_data(data_f));
   chaos_sbox_gen #(.SBOX_BITS(4), .FRAC_W(12), .R_Q(16343)) u_sm (.clk(clk), .rst(rst),
      .start(start_s), .seed(seed_s), .busy(busy_s), .done(done_s), .rd_addr(addr_s),
      .rd_inv(inv_s), .rd_data(data_s));

   task automatic check(input string name, input longint act, input longint req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic int get_busy(input int id);
      case (id)
         0: return int'(busy_d);
         1: return int'(busy_f);
         default: return int'(busy_s);
      endcase
   endfunction

   function automatic int get_done(input int id);
      case (id)
         0: return int'(done_d);
         1: return int'(done_f);
         default: return int'(done_s);
      endcase
   endfunction

   function automatic int get_data(input int id);
      case (id)
         0: return int'(data_d);
         1: return int'(data_f);
         default: return int'(data_s);
      endcase
   endfunction

   task automatic set_start(input int id, input logic s, input int sd);
      case (id)
         0: begin start_d = s; seed_d = 16'(sd); end
         1: begin start_f = s; seed_f = 16'(sd); end
         default: begin start_s = s; seed_s = 12'(sd); end
      endcase
   endtask

   task automatic set_rd(input int id, input logic iv, input int a);
      case (id)
         0: begin inv_d = iv; addr_d = 8'(a); end
         1: begin inv_f = iv; addr_f = 8'(a); end
         default: begin inv_s = iv; addr_s = 4'(a); end
      endcase
   endtask

   // Behavioural model: plain integer logistic map, first-seen filter, ascending fill of leftovers
   task automatic model(input int id, input int sd);
      int     sb = (id == 2) ? 4 : 8;
      int     fw = (id == 2) ? 12 : 16;
      longint rq = (id == 2) ? 16343 : 261489;
      int     mx = (id == 1) ? 16 : 4096;
      int     n = 1 << sb;
      bit     seen[256];
      longint x, p1, xn, one;
      int     c, cnt = 0, it = 0, f = 0;
      one = longint'(1) << fw;
      x = (sd == 0) ? 1 : sd;
      for (int v = 0; v < 256; v++) seen[v] = 1'b0;
      while (cnt < n && it < mx) begin
         p1 = (x * (one - x)) >> fw;
         xn = (rq * p1) >> fw;
         if (xn > one - 1) xn = one - 1;
         c = int'(xn >> (fw - sb));
         if (!seen[c]) begin
            seen[c] = 1'b1;
            exp_fwd[cnt] = c;
            cnt++;
         end
         x = xn;
         it++;
      end
      exp_pref = cnt;
      for (int v = 0; v < n && cnt < n; v++) begin
         f++;
         if (!seen[v]) begin
            seen[v] = 1'b1;
            exp_fwd[cnt] = v;
            cnt++;
         end
      end
      for (int i = 0; i < n; i++) exp_inv[exp_fwd[i]] = i;
      exp_lat = it + f;
   endtask

   // Compare process: registered read data must match the model one edge after the address and hold until the next edge
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         cmp_en[i]  = pend_en[i];
         cmp_exp[i] = pend_exp[i];
      end
      #1;
      for (int i = 0; i < 3; i++)
         if (cmp_en[i]) check($sformatf("rd_u%0d", i), get_data(i), cmp_exp[i]);
      @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++)
         if (cmp_en[i]) check($sformatf("rd_hold_u%0d", i), get_data(i), cmp_exp[i]);
   end

   task automatic verify(input int id, input int n);
      for (int iv = 0; iv < 2; iv++)
         for (int a = 0; a < n; a++) begin
            @(negedge clk);
            set_rd(id, 1'(iv), a);
            pend_exp[id] = (iv == 1) ? exp_inv[a] : exp_fwd[a];
            pend_en[id]  = 1'b1;
         end
      @(negedge clk);
      pend_en[id] = 1'b0;
   endtask

   task automatic rd_one(input int id, input logic iv, input int a, output int d);
      @(negedge clk);
      set_rd(id, iv, a);
      @(posedge clk);
      #1;
      d = get_data(id);
   endtask

   task automatic run(input int id, input int sd, input int glitch_at, input string tag);
      int cyc = 0;
      int n   = (id == 2) ? 16 : 256;
      int mx  = (id == 1) ? 16 : 4096;
      model(id, sd);
      @(negedge clk);
      set_start(id, 1'b1, sd);
      @(posedge clk);
      #1;
      check({tag, "_accept_busy"}, get_busy(id), 1);
      check({tag, "_accept_done"}, get_done(id), 0);
      @(negedge clk);
      set_start(id, 1'b0, sd);
      while (get_done(id) == 0 && cyc < 6000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == glitch_at) set_start(id, 1'b1, sd ^ 'h1234);
         if (cyc == glitch_at + 1) set_start(id, 1'b0, sd);
      end
      set_start(id, 1'b0, sd);
      check({tag, "_latency"}, cyc, exp_lat);
      check({tag, "_bound"}, longint'(cyc <= mx + n), 1);
      check({tag, "_busy_low"}, get_busy(id), 0);
      verify(id, n);
   endtask

   initial begin
      int d;
      for (int i = 0; i < 3; i++) begin
         pend_en[i]  = 1'b0;
         pend_exp[i] = 0;
      end
      rst = 1'b0;
      // Reset held with random inputs
      for (int k = 0; k < 6; k++) begin
         start_d = 1'($urandom); start_f = 1'($urandom); start_s = 1'($urandom);
         seed_d = 16'($urandom); seed_f = 16'($urandom); seed_s = 12'($urandom);
         addr_d = 8'($urandom); addr_f = 8'($urandom); addr_s = 4'($urandom);
         inv_d = 1'($urandom); inv_f = 1'($urandom); inv_s = 1'($urandom);
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy_u%0d", i), get_busy(i), 0);
            check($sformatf("rst_done_u%0d", i), get_done(i), 0);
            check($sformatf("rst_data_u%0d", i), get_data(i), 0);
         end
      end
      start_d = 1'b0; start_f = 1'b0; start_s = 1'b0;
      rst = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         check("idle_hold", longint'(busy_d | busy_f | busy_s | done_d | done_f | done_s), 0);
      end

      run(0, 'h3A5C, -1, "def");
      check("model_fwd0_def", exp_fwd[0], 179);
      rd_one(0, 1'b0, 0, d);
      check("dut_fwd0_def", d, 179);
      rd_one(0, 1'b1, 179, d);
      check("dut_inv179_def", d, 0);

      run(0, 0, -1, "seed0");
      model(0, 1);
      verify(0, 256);

      run(0, 'h3A5C, 20, "busy_start");

      // Reset mid-ITER, then regenerate from scratch
      @(negedge clk);
      set_start(0, 1'b1, 'h3A5C);
      @(negedge clk);
      set_start(0, 1'b0, 'h3A5C);
      repeat (50) @(posedge clk);
      #1;
      check("midrun_busy", busy_d, 1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_busy", busy_d, 0);
      check("async_rst_done", done_d, 0);
      @(negedge clk);
      rst = 1'b1;
      run(0, 'h3A5C, -1, "post_rst");

      run(1, 'h3A5C, -1, "fallback");
      check("fallback_prefix_short", longint'(exp_pref < 256), 1);
      rd_one(1, 1'b0, 0, d);
      check("dut_fwd0_fb", d, 179);

      run(2, 'h800, -1, "small");
      check("model_fwd0_small", exp_fwd[0], 15);
      check("model_fwd1_small", exp_fwd[1], 0);
      rd_one(2, 1'b0, 1, d);
      check("dut_fwd1_small", d, 0);
      rd_one(2, 1'b1, 15, d);
      check("dut_inv15_small", d, 0);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/chaos_sbox_gen.md
# chaos_sbox_gen

Parametrised chaotic S-box generator for the image-encryption datapath. It iterates a fixed-point logistic map from a programmable seed and keeps only first-seen quantised values, producing a bijective 2^SBOX_BITS-entry substitution table and its inverse. It replaces the fixed 8-bit, seed-hardwired S-box stage under `top` and adds three things that stage lacked:
- a start/busy/done handshake
- a width parameter
- a guaranteed-termination fallback

The substitution cipher and decipher stages read the tables through a registered read port.

## Interface
- SBOX_BITS, 8, table index/data width; table depth N = 2^SBOX_BITS
- FRAC_W, 16, fractional bits of map state x (Q0.FRAC_W)
- R_Q, 261489, map parameter r in Q2.FRAC_W (3.99 at FRAC_W=16)
- MAX_ITER, 4096, map iterations allowed before fallback fill
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin generation; sampled when not busy
- seed  in  FRAC_W  initial x; latched on accepted start
- busy  out  1  generation in progress
- done  out  1  table valid; level, held until next accepted start
- rd_addr  in  SBOX_BITS  table read address
- rd_inv  in  1  0 = forward table, 1 = inverse table
- rd_data  out  SBOX_BITS  registered read data

## Operation
- States: IDLE, ITER, FILL, DONE.
- **IDLE/DONE with start=1**
  - Latch seed into x; a seed of 0 is replaced by 1, because 0 is a fixed point.
  - Clear the used[N-1:0] flag vector in the same edge.
  - Set count=0 and iter=0.
  - Set busy=1 and done=0.
  - Go to ITER.
- **ITER**, one map step per cycle:
  - p1 = (x * (2^FRAC_W − x)) >> FRAC_W.
  - x_next = (R_Q * p1) >> FRAC_W, saturated to 2^FRAC_W − 1.
  - Candidate c = x_next[FRAC_W-1 -: SBOX_BITS].
  - If used[c]=0: write fwd[count]=c and inv[c]=count, set used[c]=1, increment count.
  - Otherwise discard c.
  - In both cases x←x_next and iter++.
  - If count reaches N: go to DONE.
  - Else if iter reaches MAX_ITER: go to FILL, with scan index s=0.
- **FILL**, one value per cycle:
  - If used[s]=0: write fwd[count]=s and inv[s]=count, set used[s]=1, increment count.
  - s++.
  - When count reaches N: go to DONE.
  - s never exceeds N−1 because exactly N−count values remain unused.
- **DONE**: busy=0, done=1. Tables are stable.
- start is ignored while busy=1.
- Tables are flops or RAM and are not reset. Contents are undefined until the first done.
- Arithmetic:
  - Products are full width: 2·FRAC_W+1 bits and FRAC_W+2+FRAC_W+1 bits.
  - Truncate by shift only. No rounding.

## Timing
- Reset values (rst=0, immediate): state IDLE, busy=0, done=0, rd_data=0, x=0, count=0, iter=0, used=0.
- **Start acceptance**
  - start is high at edge k: busy=1 and done=0 after edge k.
  - The first map step is evaluated at edge k+1.
- **Completion latency**
  - Without fallback: exactly (accepting iterations + rejected iterations) cycles after k.
  - Worst case: MAX_ITER + N cycles after k.
  - done rises one edge after the write of entry N−1 (the ITER/FILL→DONE transition edge).
- **Read port**
  - rd_data = table[rd_addr] selected by rd_inv, registered, 1-cycle latency.
  - It is usable whenever done=1.
  - During busy it returns in-progress content.
- **Simultaneous events**
  - start in DONE restarts at that edge; done drops the next cycle.
  - A table write and a read of the same address in the same cycle return the old value.
- **Reset mid-run**: returns to IDLE immediately. The next start regenerates from scratch, and the result is identical to an uninterrupted run with the same seed.

## Test plan
- Reset: hold rst=0 with random inputs -> busy=0, done=0, rd_data=0. Release with no start -> state stays IDLE for 100 cycles.
- Default params, seed=16'h3A5C -> done within 4352 cycles. fwd[0..255] is a permutation of 0..255. inv[fwd[i]]==i for all i. fwd[0] matches the golden fixed-point model.
- seed=0 -> table identical to seed=1.
- MAX_ITER=16, SBOX_BITS=8 -> FILL entered at iter 16. done ≤ 16+256 cycles after start. Entries after the chaotic prefix are the unused values in ascending order. Result is a valid permutation.
- Start pulse while busy, and rst pulse mid-ITER followed by a new start -> the ignored start has no effect. The post-reset table equals an uninterrupted run with the same seed.
- SBOX_BITS=4, FRAC_W=12, R_Q=16343 -> 16-entry permutation. rd_data follows rd_addr/rd_inv with 1-cycle latency.
